// File: rtl/tseq_pkg.sv
// Shared types and default constants for the processor test sequencer.
package tseq_pkg;

  localparam int TSEQ_DATA_W       = 32;
  localparam int TSEQ_NUM_REGS     = 32;
  localparam int TSEQ_IDX_W        = 5;
  localparam int TSEQ_RESET_CYCLES = 2;
  localparam int TSEQ_CNT_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    CHECK,
    DONE
  } tseq_state_t;

  typedef struct packed {
    logic                    pass;
    logic [TSEQ_IDX_W:0]     mismatch_count;
    logic [TSEQ_IDX_W-1:0]   fail_idx;
    logic [TSEQ_DATA_W-1:0]  fail_actual;
    logic [TSEQ_DATA_W-1:0]  fail_expected;
  } tseq_result_t;

endpackage

// File: rtl/tseq_cycle_counter.sv
// Loadable down-counter with zero flag, shared by the RST and RUN phases.
module tseq_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dut_test_sequencer.sv
// Run controller: reset, run and freeze the processor, then scan its registers.
// Build with TSEQ_STOP_ON_FAIL_EN to end the scan at the first mismatch.
module dut_test_sequencer
  import tseq_pkg::*;
#(
  parameter int DATA_W       = TSEQ_DATA_W,
  parameter int NUM_REGS     = TSEQ_NUM_REGS,
  parameter int IDX_W        = TSEQ_IDX_W,
  parameter int RESET_CYCLES = TSEQ_RESET_CYCLES,
  parameter int CNT_W        = TSEQ_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_cycles,
  output logic              dut_reset,
  output logic              dut_clk_en,
  output logic [IDX_W-1:0]  reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [IDX_W-1:0]  exp_raddr,
  input  logic [DATA_W-1:0] exp_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    mismatch_count,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_actual,
  output logic [DATA_W-1:0] fail_expected
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W:0]   MM_MAX   = '1;
  localparam int               RST_LD_I =
    (RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_LD_I);

  tseq_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  runs_q, runs_d;
  logic [IDX_W:0]    mm_q, mm_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [DATA_W-1:0] fact_q, fact_d;
  logic [DATA_W-1:0] fexp_q, fexp_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_en;
  logic              cnt_zero;
  logic              miss;

  tseq_cycle_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  assign miss = (reg_rdata != exp_rdata);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    runs_d   = runs_q;
    mm_d     = mm_q;
    fidx_d   = fidx_q;
    fact_d   = fact_q;
    fexp_d   = fexp_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          runs_d   = (run_cycles == '0) ? CNT_W'(1) : run_cycles;
          mm_d     = '0;
          fidx_d   = '0;
          fact_d   = '0;
          fexp_d   = '0;
          idx_d    = '0;
          cnt_load = 1'b1;
          cnt_val  = RST_LD;
          state_d  = RST;
        end
      end
      RST: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = runs_q - CNT_W'(1);
          state_d  = RUN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RUN: begin
        if (cnt_zero) begin
          idx_d   = IDX_W'(1);
          state_d = CHECK;
        end else begin
          cnt_en = 1'b1;
        end
      end
      CHECK: begin
        if (miss) begin
          if (mm_q != MM_MAX) begin
            mm_d = mm_q + (IDX_W+1)'(1);
          end
          if (mm_q == '0) begin
            fidx_d = idx_q;
            fact_d = reg_rdata;
            fexp_d = exp_rdata;
          end
        end
`ifdef TSEQ_STOP_ON_FAIL_EN
        if (miss || (idx_q == LAST_IDX)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
`else
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      runs_q  <= '0;
      mm_q    <= '0;
      fidx_q  <= '0;
      fact_q  <= '0;
      fexp_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      runs_q  <= runs_d;
      mm_q    <= mm_d;
      fidx_q  <= fidx_d;
      fact_q  <= fact_d;
      fexp_q  <= fexp_d;
    end
  end

  assign dut_reset      = (state_q == IDLE) || (state_q == RST);
  assign dut_clk_en     = (state_q == RST) || (state_q == RUN);
  assign busy           = (state_q == RST) || (state_q == RUN) ||
                          (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign pass           = done && (mm_q == '0);
  assign reg_raddr      = idx_q;
  assign exp_raddr      = idx_q;
  assign mismatch_count = mm_q;
  assign fail_idx       = fidx_q;
  assign fail_actual    = fact_q;
  assign fail_expected  = fexp_q;

endmodule

// File: tb/tb_dut_test_sequencer.sv
// Scoreboard bench for dut_test_sequencer with an 8-entry stub register file.
module tb_dut_test_sequencer;

  localparam int DW  = 32;
  localparam int NR  = 8;
  localparam int IW  = 3;
  localparam int RC  = 2;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] run_cycles = '0;
  logic          dut_reset, dut_clk_en, busy, done, pass;
  logic [IW-1:0] reg_raddr, exp_raddr, fail_idx;
  logic [DW-1:0] reg_rdata, exp_rdata, fail_actual, fail_expected;
  logic [IW:0]   mismatch_count;

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] expv [NR];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        pass;
    int          cnt;
    int          fidx;
    logic [31:0] fact;
    logic [31:0] fexp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign reg_rdata = regs[reg_raddr];
  assign exp_rdata = expv[exp_raddr];

  dut_test_sequencer #(
    .DATA_W       (DW),
    .NUM_REGS     (NR),
    .IDX_W        (IW),
    .RESET_CYCLES (RC),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .run_cycles     (run_cycles),
    .dut_reset      (dut_reset),
    .dut_clk_en     (dut_clk_en),
    .reg_raddr      (reg_raddr),
    .reg_rdata      (reg_rdata),
    .exp_raddr      (exp_raddr),
    .exp_rdata      (exp_rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .fail_idx       (fail_idx),
    .fail_actual    (fail_actual),
    .fail_expected  (fail_expected)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("pass", 64'(pass), 64'(e.pass));
        chk("mismatch_count", 64'(mismatch_count), 64'(e.cnt));
        chk("fail_idx", 64'(fail_idx), 64'(e.fidx));
        chk("fail_actual", 64'(fail_actual), 64'(e.fact));
        chk("fail_expected", 64'(fail_expected), 64'(e.fexp));
      end
    end
    done_prev = done;
  end

  task automatic init_regs();
    for (int i = 0; i < NR; i++) begin
      regs[i] = 32'h1000_0000 + i;
      expv[i] = 32'h1000_0000 + i;
    end
  endtask

  task automatic kick(input int rc);
    @(negedge clk);
    run_cycles = CW'(rc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = edges from the start edge to the edge where done rises
  task automatic go(input int rc, input logic p, input int cnt,
                    input int fidx, input logic [31:0] fa,
                    input logic [31:0] fe, input int lat);
    exp_t e;
    @(negedge clk);
    run_cycles = CW'(rc);
    start = 1'b1;
    e.cyc = cyc + 1 + lat;
    e.pass = p;
    e.cnt = cnt;
    e.fidx = fidx;
    e.fact = fa;
    e.fexp = fe;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [13:0] rv, cv;
    init_regs();
    #1;
    chk("rst_dut_reset", 64'(dut_reset), 64'd1);
    chk("rst_clk_en", 64'(dut_clk_en), 64'd0);
    chk("rst_raddr", 64'(reg_raddr), 64'd0);
    chk("rst_busy_done_pass", 64'({busy, done, pass}), 64'd0);
    chk("rst_results", 64'({mismatch_count, fail_idx}), 64'd0);
    chk("rst_fail_vals", {fail_actual, fail_expected}, 64'd0);
    #20;
    reset = 1'b0;

    // 1: exact match, phase timing
    go(4, 1'b1, 0, 0, 32'h0, 32'h0, 13);
    for (int j = 1; j <= 14; j++) begin
      rv[j-1] = dut_reset;
      cv[j-1] = dut_clk_en;
      if (j < 14) @(negedge clk);
    end
    chk("dut_reset_window", 64'(rv), 64'h0003);
    chk("dut_clk_en_window", 64'(cv), 64'h003f);
    wait_done();

    // 2: single mismatch at register 3
    regs[3] = 32'hcafebabe;
    expv[3] = 32'h0000_0005;
`ifdef TSEQ_STOP_ON_FAIL_EN
    go(4, 1'b0, 1, 3, 32'hcafebabe, 32'h5, 9);
`else
    go(4, 1'b0, 1, 3, 32'hcafebabe, 32'h5, 13);
`endif
    wait_done();
    init_regs();

    // 3: mismatches at 2 and 6
    regs[2] = 32'hdead0002;
    regs[6] = 32'hdead0006;
`ifdef TSEQ_STOP_ON_FAIL_EN
    go(4, 1'b0, 1, 2, 32'hdead0002, 32'h1000_0002, 8);
`else
    go(4, 1'b0, 2, 2, 32'hdead0002, 32'h1000_0002, 13);
`endif
    wait_done();
    init_regs();

    // 6: restart from DONE clears results, same timing
    chk("done_before_restart", 64'(done), 64'd1);
    go(4, 1'b1, 0, 0, 32'h0, 32'h0, 13);
    chk("restart_cleared_cnt", 64'(mismatch_count), 64'd0);
    chk("restart_cleared_fail",
        {32'(fail_idx), fail_actual}, 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_done();

    // 4: run_cycles=0 runs one cycle; start during RUN ignored
    go(0, 1'b1, 0, 0, 32'h0, 32'h0, 10);
    @(negedge clk);
    @(negedge clk);
    chk("run_phase_clk_en", 64'({dut_reset, dut_clk_en}), 64'b01);
    start = 1'b1;
    run_cycles = CW'(9);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // 5: reset mid-RUN aborts, then a clean run
    kick(4);
    repeat (3) @(negedge clk);
    chk("mid_run_state", 64'({dut_reset, dut_clk_en}), 64'b01);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_dut_reset", 64'(dut_reset), 64'd1);
    chk("abort_busy_done", 64'({busy, dut_clk_en, done}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    go(4, 1'b1, 0, 0, 32'h0, 32'h0, 13);
    wait_done();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dut_test_sequencer.md
Name: dut_test_sequencer

Overview:
Synthesizable, parametrised successor to the hand-timed processor bench flow: a self-checking run controller for the single-cycle processor. It resets the DUT, runs it for a programmed cycle count, and freezes it. It then scans the register file through a read port against an expected-value table and reports pass/fail, first failure and mismatch count. It sits beside the processor in simulation and FPGA bring-up tops and replaces fixed delays and loop-based checking.

Parameters:
DATA_W, 32, register and expected-value width
NUM_REGS, 32, register count; register 0 is never checked
IDX_W, 5, index width, equal to clog2(NUM_REGS)
RESET_CYCLES, 2, cycles dut_reset is held after start
CNT_W, 16, width of the run-cycle counter and run_cycles input

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset of the sequencer
start  in  1  begin a test run; sampled only in IDLE or DONE
run_cycles  in  CNT_W  DUT run length, latched on start; 0 is treated as 1
dut_reset  out  1  reset driven to the processor
dut_clk_en  out  1  clock enable to the processor; 0 freezes architectural state
reg_raddr  out  IDX_W  register-file debug read address (combinational read)
reg_rdata  in  DATA_W  register-file read data for reg_raddr
exp_raddr  out  IDX_W  expected-table read address, always equal to reg_raddr
exp_rdata  in  DATA_W  expected value (combinational read)
busy  out  1  high from the start edge until DONE
done  out  1  high while in DONE
pass  out  1  valid when done; 1 iff mismatch_count==0
mismatch_count  out  IDX_W+1  mismatching registers in the last run
fail_idx  out  IDX_W  index of the first mismatch
fail_actual  out  DATA_W  value read at the first mismatch
fail_expected  out  DATA_W  expected value at the first mismatch

Behaviour:
- States: IDLE, RST, RUN, CHECK, DONE.
- Reset values: state=IDLE, dut_reset=1, dut_clk_en=0, reg_raddr=0, busy=0, done=0, pass=0. Counters, mismatch_count, fail_idx, fail_actual and fail_expected are all 0.
- IDLE: dut_reset=1, dut_clk_en=0. On start=1 the sequencer:
  - latches max(run_cycles,1);
  - clears mismatch_count and the fail_* outputs;
  - goes to RST.
- RST: dut_reset=1, dut_clk_en=1 for exactly RESET_CYCLES cycles, then goes to RUN.
- RUN: dut_reset=0, dut_clk_en=1 for exactly the latched run count, then goes to CHECK with reg_raddr=1.
- CHECK: dut_reset=0, dut_clk_en=0, one register per cycle for idx=1..NUM_REGS-1.
  - Each cycle compares reg_rdata against exp_rdata.
  - On a mismatch, mismatch_count increments, saturating at its maximum.
  - On the first mismatch only, fail_idx, fail_actual and fail_expected capture idx, reg_rdata and exp_rdata.
  - After idx=NUM_REGS-1 the sequencer goes to DONE.
- DONE: done=1, pass=(mismatch_count==0), dut_clk_en=0, dut_reset=0 (DUT state stays inspectable). start=1 restarts exactly as from IDLE.
- Latency: start is sampled at edge E. done rises at edge E + RESET_CYCLES + runs + (NUM_REGS-1), where runs is the latched run count.
- start is ignored in RST, RUN and CHECK. run_cycles changes after the start edge have no effect.
- Asserting reset at any point returns the sequencer to IDLE immediately. dut_reset asserts asynchronously and all results clear.
- NUM_REGS=2 checks only register 1. Index arithmetic is unsigned and never wraps past NUM_REGS-1.

Optional Feature:
TSEQ_STOP_ON_FAIL_EN
- Defined: the first mismatch ends CHECK and the sequencer goes to DONE in the following cycle. mismatch_count is then 0 or 1.
- Undefined: all registers are always scanned and mismatch_count is the full total.

Decomposition:
- Package tseq_pkg holds:
  - the state enum (IDLE..DONE);
  - the default parameter constants;
  - a result struct {pass, mismatch_count, fail_idx, fail_actual, fail_expected}.
- One natural sub-module: tseq_cycle_counter, a loadable down-counter with a zero flag. It is reused for the RST and RUN phases.

Test Plan:
Setup: RESET_CYCLES=2, NUM_REGS=8, run_cycles=4, pulse start at edge 0. The stub register file returns an index-derived value and the expected table matches it.
1. Exact match -> dut_reset high for edges 1-2, dut_clk_en high for edges 1-6, CHECK covers idx 1..7, done rises at edge 13, pass=1, mismatch_count=0.
2. Register 3 = 0xcafebabe, expected 0x00000005 -> pass=0, mismatch_count=1, fail_idx=3, fail_actual=0xcafebabe, fail_expected=0x00000005.
3. Registers 2 and 6 mismatch -> mismatch_count=2, fail_idx=2. With TSEQ_STOP_ON_FAIL_EN: done rises one cycle after idx 2, mismatch_count=1.
4. run_cycles=0 -> runs exactly 1 DUT cycle, done at edge 10. Pulsing start during RUN changes nothing.
5. reset asserted mid-RUN -> dut_reset=1 and state=IDLE immediately, done=0. A following start completes normally with pass=1.
6. start in DONE -> results clear, sequence repeats with identical timing.
